// File: rtl/mips_pkg.sv
// MIPS opcode/funct constants and default physical register sizing
// shared by the rename slice.
package mips_pkg;

   localparam int NUM_PREGS_D = 64;
   localparam int PREG_W_D    = 6;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SWL    = 6'h2A;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;

   localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/rename_stage_if.sv
// Rename-queue -> rename -> issue-queue handshake and instruction bus.
// master drives instructions in, slave is the rename stage.
interface rename_stage_if #(
   parameter int PREG_W = 6
);

   logic        IN_VALID;
   logic        STALL_OUT_RQ;
   logic [31:0] Instr_IN;
   logic [31:0] Instr_PC_IN;
   logic [5:0]  opcode_IN;
   logic [4:0]  rs_IN;
   logic [4:0]  rt_IN;
   logic [4:0]  rd_IN;
   logic [4:0]  shiftAmount_IN;
   logic [5:0]  funct_IN;
   logic [15:0] immediate_IN;
   logic [25:0] target_IN;

   logic              STALL_IN_IQ;
   logic              OUT_VALID;
   logic [31:0]       Instr_OUT;
   logic [31:0]       Instr_PC_OUT;
   logic [5:0]        opcode_OUT;
   logic [4:0]        shiftAmount_OUT;
   logic [5:0]        funct_OUT;
   logic [15:0]       immediate_OUT;
   logic [25:0]       target_OUT;
   logic [PREG_W-1:0] prs_OUT;
   logic [PREG_W-1:0] prt_OUT;
   logic [PREG_W-1:0] prd_OUT;
   logic [PREG_W-1:0] old_prd_OUT;
   logic              dest_valid_OUT;

   modport master (
      output IN_VALID, Instr_IN, Instr_PC_IN, opcode_IN, rs_IN, rt_IN,
             rd_IN, shiftAmount_IN, funct_IN, immediate_IN, target_IN,
             STALL_IN_IQ,
      input  STALL_OUT_RQ, OUT_VALID, Instr_OUT, Instr_PC_OUT,
             opcode_OUT, shiftAmount_OUT, funct_OUT, immediate_OUT,
             target_OUT, prs_OUT, prt_OUT, prd_OUT, old_prd_OUT,
             dest_valid_OUT
   );

   modport slave (
      input  IN_VALID, Instr_IN, Instr_PC_IN, opcode_IN, rs_IN, rt_IN,
             rd_IN, shiftAmount_IN, funct_IN, immediate_IN, target_IN,
             STALL_IN_IQ,
      output STALL_OUT_RQ, OUT_VALID, Instr_OUT, Instr_PC_OUT,
             opcode_OUT, shiftAmount_OUT, funct_OUT, immediate_OUT,
             target_OUT, prs_OUT, prt_OUT, prd_OUT, old_prd_OUT,
             dest_valid_OUT
   );

endinterface

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical tags; starts full with tags 32..NUM_PREGS-1.
// Overflow is sticky until reset/flush.
module free_list #(
   parameter int NUM_PREGS = 64,
   parameter int PREG_W    = 6,
   localparam int DEPTH    = NUM_PREGS - 32,
   localparam int PTR_W    = $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SYS,
   input  logic              alloc,
   input  logic              free_valid,
   input  logic [PREG_W-1:0] free_preg,
   output logic [PREG_W-1:0] head_preg,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              ovf
);

   logic [PREG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic              full;
   logic              push;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_preg = mem[head];
   // when full, a same-cycle allocation frees the slot being written
   assign push      = free_valid & (~full | alloc);

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(DEPTH);
         ovf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= PREG_W'(32 + i);
      end else if (SYS) begin
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(DEPTH);
         ovf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= PREG_W'(32 + i);
      end else begin
         if (alloc)
            head <= inc(head);
         if (push) begin
            mem[tail] <= free_preg;
            tail      <= inc(tail);
         end
         if (push && !alloc)
            count <= count + 1'b1;
         else if (alloc && !push)
            count <= count - 1'b1;
         if (free_valid && full && !alloc)
            ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/rename_stage.sv
// Single-issue MIPS rename stage: RAT lookup, destination allocation
// from the free list, one-entry output register toward the IQ.
module rename_stage
   import mips_pkg::*;
#(
   parameter int NUM_PREGS = NUM_PREGS_D,
   parameter int PREG_W    = PREG_W_D,
   localparam int CNT_W    = $clog2(NUM_PREGS - 32 + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SYS,
   rename_stage_if.slave     rn,
   input  logic              FREE_VALID,
   input  logic [PREG_W-1:0] FREE_PREG,
   output logic              FREE_OVF
);

   typedef struct packed {
      logic              valid;
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [5:0]        opcode;
      logic [4:0]        sham;
      logic [5:0]        funct;
      logic [15:0]       imm;
      logic [25:0]       tgt;
      logic [PREG_W-1:0] prs;
      logic [PREG_W-1:0] prt;
      logic [PREG_W-1:0] prd;
      logic [PREG_W-1:0] old_prd;
      logic              dest_valid;
   } out_t;

   logic [PREG_W-1:0] rat [32];
   out_t              out_q;
   logic [4:0]        arch_dest;
   logic              fn_nodest;
   logic              op_nodest;
   logic              needs_dest;
   logic              accept;
   logic              alloc;
   logic [PREG_W-1:0] fl_head;
   logic [CNT_W-1:0]  fl_count;
   logic              fl_empty;

   assign fn_nodest = rn.funct_IN inside {FN_JR, FN_SYSCALL, FN_MULT,
                                          FN_MULTU, FN_DIV, FN_DIVU};
   assign op_nodest = rn.opcode_IN inside {OP_REGIMM, OP_J, OP_BEQ,
                                           OP_BNE, OP_BLEZ, OP_BGTZ,
                                           OP_SB, OP_SH, OP_SWL, OP_SW};

   always_comb begin
      arch_dest = rn.rt_IN;
      unique case (1'b1)
         (rn.opcode_IN == OP_RTYPE): arch_dest = fn_nodest ? '0 : rn.rd_IN;
         (rn.opcode_IN == OP_JAL):   arch_dest = REG_RA;
         op_nodest:                  arch_dest = '0;
         default:                    arch_dest = rn.rt_IN;
      endcase
   end

   // $0 as destination is a no-op write: no tag consumed
   assign needs_dest = |arch_dest;

   assign rn.STALL_OUT_RQ = (out_q.valid & rn.STALL_IN_IQ)
                          | (needs_dest & fl_empty);
   assign accept = rn.IN_VALID & ~rn.STALL_OUT_RQ;
   assign alloc  = accept & needs_dest;

   free_list #(
      .NUM_PREGS (NUM_PREGS),
      .PREG_W    (PREG_W)
   ) u_free_list (
      .CLK        (CLK),
      .RESET      (RESET),
      .SYS        (SYS),
      .alloc      (alloc),
      .free_valid (FREE_VALID),
      .free_preg  (FREE_PREG),
      .head_preg  (fl_head),
      .count      (fl_count),
      .empty      (fl_empty),
      .ovf        (FREE_OVF)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 32; i++)
            rat[i] <= PREG_W'(i);
      end else if (SYS) begin
         for (int i = 0; i < 32; i++)
            rat[i] <= PREG_W'(i);
      end else if (alloc) begin
         rat[arch_dest] <= fl_head;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         out_q <= '0;
      end else if (SYS) begin
         out_q <= '0;
      end else if (accept) begin
         out_q.valid      <= 1'b1;
         out_q.instr      <= rn.Instr_IN;
         out_q.pc         <= rn.Instr_PC_IN;
         out_q.opcode     <= rn.opcode_IN;
         out_q.sham       <= rn.shiftAmount_IN;
         out_q.funct      <= rn.funct_IN;
         out_q.imm        <= rn.immediate_IN;
         out_q.tgt        <= rn.target_IN;
         out_q.prs        <= rat[rn.rs_IN];
         out_q.prt        <= rat[rn.rt_IN];
         out_q.prd        <= needs_dest ? fl_head : '0;
         out_q.old_prd    <= needs_dest ? rat[arch_dest] : '0;
         out_q.dest_valid <= needs_dest;
      end else if (!rn.STALL_IN_IQ) begin
         out_q.valid <= 1'b0;
      end
   end

   assign rn.OUT_VALID       = out_q.valid;
   assign rn.Instr_OUT       = out_q.instr;
   assign rn.Instr_PC_OUT    = out_q.pc;
   assign rn.opcode_OUT      = out_q.opcode;
   assign rn.shiftAmount_OUT = out_q.sham;
   assign rn.funct_OUT       = out_q.funct;
   assign rn.immediate_OUT   = out_q.imm;
   assign rn.target_OUT      = out_q.tgt;
   assign rn.prs_OUT         = out_q.prs;
   assign rn.prt_OUT         = out_q.prt;
   assign rn.prd_OUT         = out_q.prd;
   assign rn.old_prd_OUT     = out_q.old_prd;
   assign rn.dest_valid_OUT  = out_q.dest_valid;

   a_alloc_nonempty: assert property (
      @(posedge CLK) disable iff (RESET) alloc |-> (fl_count != '0));

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a reference RAT/free-list model
// predicts every accepted instruction and the output register each cycle.
module tb_rename_stage;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SYS;
  logic       FREE_VALID;
  logic [5:0] FREE_PREG;
  logic       FREE_OVF;

  rename_stage_if #(.PREG_W(6)) rn ();

  rename_stage #(.NUM_PREGS(64), .PREG_W(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SYS        (SYS),
    .rn         (rn),
    .FREE_VALID (FREE_VALID),
    .FREE_PREG  (FREE_PREG),
    .FREE_OVF   (FREE_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [5:0]  prs;
    logic [5:0]  prt;
    logic [5:0]  prd;
    logic [5:0]  old;
    logic        dv;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [5:0]  mrat [32];
  logic [5:0]  mfl [$];
  exp_t        sb [$];
  exp_t        last;
  bit          m_ov;
  bit          m_ovf;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] bdest(logic [5:0] op, logic [4:0] rt,
                                       logic [4:0] rd, logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h0C || (fn >= 6'h18 && fn <= 6'h1B))
          return 5'd0;
        return rd;
      end
      6'h03: return 5'd31;
      6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h28, 6'h29, 6'h2A, 6'h2B: return 5'd0;
      default: return rt;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrat[i] = 6'(i);
    mfl.delete();
    for (int i = 0; i < 32; i++) mfl.push_back(6'(32 + i));
    sb.delete();
    m_ov  = 0;
    m_ovf = 0;
    last  = '{default: '0};
  endtask

  task automatic set_in(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                        logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    logic [31:0] w;
    w = {op, rs, rt, rd, sh, fn};
    rn.IN_VALID       = 1'b1;
    rn.Instr_IN       = w;
    rn.Instr_PC_IN    = pc_ctr;
    rn.opcode_IN      = op;
    rn.rs_IN          = rs;
    rn.rt_IN          = rt;
    rn.rd_IN          = rd;
    rn.shiftAmount_IN = sh;
    rn.funct_IN       = fn;
    rn.immediate_IN   = w[15:0];
    rn.target_IN      = w[25:0];
    pc_ctr            = pc_ctr + 4;
  endtask

  task automatic idle();
    set_in(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00);
    rn.IN_VALID = 1'b0;
  endtask

  task automatic rand_instr();
    logic [5:0] ops [15];
    logic [5:0] fns [8];
    ops = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h01, 6'h02, 6'h04, 6'h05,
            6'h08, 6'h09, 6'h23, 6'h2B, 6'h28, 6'h0F, 6'h0D};
    fns = '{6'h20, 6'h21, 6'h08, 6'h0C, 6'h18, 6'h1A, 6'h1B, 6'h2A};
    set_in(ops[$urandom_range(0, 14)], 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), fns[$urandom_range(0, 7)]);
  endtask

  task automatic chk_out();
    chk("out_valid", 32'(rn.OUT_VALID), 32'(m_ov));
    chk("free_ovf", 32'(FREE_OVF), 32'(m_ovf));
    chk("instr", rn.Instr_OUT, last.instr);
    chk("pc", rn.Instr_PC_OUT, last.pc);
    chk("opcode", 32'(rn.opcode_OUT), 32'(last.op));
    chk("shamt", 32'(rn.shiftAmount_OUT), 32'(last.sh));
    chk("funct", 32'(rn.funct_OUT), 32'(last.fn));
    chk("imm", 32'(rn.immediate_OUT), 32'(last.imm));
    chk("target", 32'(rn.target_OUT), 32'(last.tgt));
    chk("prs", 32'(rn.prs_OUT), 32'(last.prs));
    chk("prt", 32'(rn.prt_OUT), 32'(last.prt));
    chk("prd", 32'(rn.prd_OUT), 32'(last.prd));
    chk("old_prd", 32'(rn.old_prd_OUT), 32'(last.old));
    chk("dest_valid", 32'(rn.dest_valid_OUT), 32'(last.dv));
  endtask

  task automatic tick();
    exp_t       e;
    logic [4:0] d;
    bit         nd, stl, acc;
    #1;
    d   = bdest(rn.opcode_IN, rn.rt_IN, rn.rd_IN, rn.funct_IN);
    nd  = (d != 5'd0);
    stl = (m_ov && rn.STALL_IN_IQ) || (nd && mfl.size() == 0);
    if (rn.IN_VALID && !SYS)
      chk("stall_out_rq", 32'(rn.STALL_OUT_RQ), 32'(stl));
    acc = rn.IN_VALID && !stl && !SYS;
    if (SYS) begin
      model_reset();
    end else begin
      if (acc) begin
        e.instr = rn.Instr_IN;
        e.pc    = rn.Instr_PC_IN;
        e.op    = rn.opcode_IN;
        e.fn    = rn.funct_IN;
        e.sh    = rn.shiftAmount_IN;
        e.imm   = rn.immediate_IN;
        e.tgt   = rn.target_IN;
        e.prs   = mrat[rn.rs_IN];
        e.prt   = mrat[rn.rt_IN];
        e.dv    = nd;
        e.prd   = 6'd0;
        e.old   = 6'd0;
        if (nd) begin
          e.prd   = mfl.pop_front();
          e.old   = mrat[d];
          mrat[d] = e.prd;
        end
        sb.push_back(e);
      end
      if (FREE_VALID) begin
        if (mfl.size() < 32) mfl.push_back(FREE_PREG);
        else m_ovf = 1;
      end
      if (acc) m_ov = 1;
      else if (!rn.STALL_IN_IQ) m_ov = 0;
    end
    @(posedge CLK);
    #1;
    if (acc) last = sb.pop_front();
    chk_out();
  endtask

  initial begin
    RESET          = 1'b1;
    SYS            = 1'b0;
    FREE_VALID     = 1'b0;
    FREE_PREG      = 6'd0;
    rn.STALL_IN_IQ = 1'b0;
    idle();
    model_reset();
    #2;
    chk("rst_out_valid", 32'(rn.OUT_VALID), 32'd0);
    chk("rst_prd", 32'(rn.prd_OUT), 32'd0);
    chk("rst_instr", rn.Instr_OUT, 32'd0);
    chk("rst_ovf", 32'(FREE_OVF), 32'd0);
    chk("rst_stall", 32'(rn.STALL_OUT_RQ), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    set_in(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    tick();
    chk("add_prs", 32'(rn.prs_OUT), 32'd1);
    chk("add_prt", 32'(rn.prt_OUT), 32'd2);
    chk("add_prd", 32'(rn.prd_OUT), 32'd32);
    chk("add_old", 32'(rn.old_prd_OUT), 32'd3);
    chk("add_dv", 32'(rn.dest_valid_OUT), 32'd1);

    set_in(6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h05);
    tick();
    chk("addi_prs", 32'(rn.prs_OUT), 32'd32);
    chk("addi_prd", 32'(rn.prd_OUT), 32'd33);
    chk("addi_old", 32'(rn.old_prd_OUT), 32'd4);

    set_in(6'h2B, 5'd6, 5'd5, 5'd0, 5'd0, 6'h00);
    tick();
    chk("sw_dv", 32'(rn.dest_valid_OUT), 32'd0);
    chk("sw_prd", 32'(rn.prd_OUT), 32'd0);
    set_in(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20);
    tick();
    chk("add0_dv", 32'(rn.dest_valid_OUT), 32'd0);
    set_in(6'h00, 5'd4, 5'd3, 5'd7, 5'd0, 6'h20);
    tick();
    chk("count_kept_prd", 32'(rn.prd_OUT), 32'd34);
    chk("fwd_prs", 32'(rn.prs_OUT), 32'd33);

    for (int k = 0; k < 40; k++) begin
      rn.STALL_IN_IQ = ($urandom_range(0, 9) < 3);
      FREE_VALID     = ($urandom_range(0, 4) == 0);
      FREE_PREG      = 6'($urandom_range(1, 63));
      if ($urandom_range(0, 4) != 0) rand_instr();
      else idle();
      tick();
    end

    FREE_VALID     = 1'b0;
    rn.STALL_IN_IQ = 1'b0;
    idle();
    SYS = 1'b1;
    tick();
    SYS = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_in(6'h08, 5'($urandom_range(0, 31)), 5'(i % 31 + 1), 5'd0,
             5'd0, 6'(i));
      tick();
    end
    set_in(6'h08, 5'd1, 5'd9, 5'd0, 5'd0, 6'h01);
    #1;
    chk("stall_33", 32'(rn.STALL_OUT_RQ), 32'd1);
    FREE_VALID = 1'b1;
    FREE_PREG  = 6'd40;
    tick();
    FREE_VALID = 1'b0;
    tick();
    chk("prd_40", 32'(rn.prd_OUT), 32'd40);

    idle();
    SYS = 1'b1;
    tick();
    SYS = 1'b0;
    rn.STALL_IN_IQ = 1'b1;
    set_in(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    tick();
    set_in(6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h20);
    #1;
    chk("iq_stall", 32'(rn.STALL_OUT_RQ), 32'd1);
    tick();
    tick();
    chk("held_prd", 32'(rn.prd_OUT), 32'd32);
    chk("held_ov", 32'(rn.OUT_VALID), 32'd1);
    SYS = 1'b1;
    tick();
    SYS = 1'b0;
    chk("sys_ov", 32'(rn.OUT_VALID), 32'd0);
    rn.STALL_IN_IQ = 1'b0;
    set_in(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    tick();
    chk("sys_prs", 32'(rn.prs_OUT), 32'd1);
    chk("sys_prt", 32'(rn.prt_OUT), 32'd2);
    chk("sys_prd", 32'(rn.prd_OUT), 32'd32);
    chk("sys_old", 32'(rn.old_prd_OUT), 32'd3);

    idle();
    SYS = 1'b1;
    tick();
    SYS        = 1'b0;
    FREE_VALID = 1'b1;
    FREE_PREG  = 6'd5;
    tick();
    FREE_VALID = 1'b0;
    chk("ovf_set", 32'(FREE_OVF), 32'd1);
    set_in(6'h00, 5'd2, 5'd3, 5'd8, 5'd0, 6'h21);
    tick();
    idle();
    repeat (3) tick();
    chk("ovf_sticky", 32'(FREE_OVF), 32'd1);

    RESET = 1'b1;
    #1;
    chk("ovf_reset", 32'(FREE_OVF), 32'd0);
    chk("rst2_ov", 32'(rn.OUT_VALID), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    set_in(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00);
    tick();
    chk("jal_old", 32'(rn.old_prd_OUT), 32'd31);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
